// File: rtl/frame_draw_sequencer_pkg.sv
// Shared definitions for the frame draw sequencer: FSM states, default screen size
// and the erase colour.
package frame_draw_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ERASE = 2'd1,
        ST_DRAW  = 2'd2,
        ST_CHECK = 2'd3
    } state_e;

    localparam int unsigned DEF_SCREEN_W = 160;
    localparam int unsigned DEF_SCREEN_H = 120;
    localparam int unsigned COLOUR_BLACK = 0;

endpackage

// File: rtl/frame_draw_sequencer_erase_sweep_counter.sv
// Raster counter for the screen erase: x is the inner loop, y the outer loop.
// last_o flags the final pixel (W-1, H-1) of the sweep.
module erase_sweep_counter #(
    parameter int unsigned XW = 8,
    parameter int unsigned YW = 7,
    parameter int unsigned W  = 160,
    parameter int unsigned H  = 120
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          clr_i,
    input  logic          en_i,
    output logic [XW-1:0] x_o,
    output logic [YW-1:0] y_o,
    output logic          last_o
);

    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;

    assign x_o    = x_q;
    assign y_o    = y_q;
    assign last_o = (x_q == XW'(W - 1)) && (y_q == YW'(H - 1));

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (clr_i) begin
            x_d = '0;
            y_d = '0;
        end else if (en_i) begin
            if (x_q == XW'(W - 1)) begin
                x_d = '0;
                y_d = (y_q == YW'(H - 1)) ? '0 : y_q + YW'(1);
            end else begin
                x_d = x_q + XW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

endmodule

// File: rtl/frame_draw_sequencer.sv
// Frame sequencer owning the vga_adapter plot port: erases the screen, then grants
// drawing clients round-robin slots, and tracks both player scores up to a win threshold.
module frame_draw_sequencer
    import frame_draw_sequencer_pkg::*;
#(
    parameter int unsigned N_CLIENTS = 4,
    parameter int unsigned XW        = 8,
    parameter int unsigned YW        = 7,
    parameter int unsigned CW        = 3,
    parameter int unsigned SCREEN_W  = DEF_SCREEN_W,
    parameter int unsigned SCREEN_H  = DEF_SCREEN_H,
    parameter int unsigned SCW       = 4,
    parameter int unsigned WIN_SCORE = 7,
    parameter int unsigned TIMEOUT   = 65535
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    go,
    input  logic [N_CLIENTS-1:0]    client_en,
    output logic [N_CLIENTS-1:0]    cl_start,
    input  logic [N_CLIENTS-1:0]    cl_done,
    input  logic [N_CLIENTS-1:0]    cl_plot,
    input  logic [N_CLIENTS*XW-1:0] cl_x,
    input  logic [N_CLIENTS*YW-1:0] cl_y,
    input  logic [N_CLIENTS*CW-1:0] cl_colour,
    input  logic                    score0_evt,
    input  logic                    score1_evt,
    output logic [XW-1:0]           x_out,
    output logic [YW-1:0]           y_out,
    output logic [CW-1:0]           colour_out,
    output logic                    plot_out,
    output logic [SCW-1:0]          score0,
    output logic [SCW-1:0]          score1,
    output logic                    game_over,
    output logic                    timeout_err
);

    localparam int unsigned IW = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    state_e               state_q;
    logic [IW-1:0]        idx_q;
    logic [TW-1:0]        age_q;
    logic [N_CLIENTS-1:0] cl_start_q;
    logic [XW-1:0]        x_q;
    logic [YW-1:0]        y_q;
    logic [CW-1:0]        colour_q;
    logic                 plot_q;
    logic [SCW-1:0]       score0_q, score0_d;
    logic [SCW-1:0]       score1_q, score1_d;
    logic                 game_over_q;
    logic                 timeout_err_q;

    logic [XW-1:0]        er_x;
    logic [YW-1:0]        er_y;
    logic                 er_last;
    logic [N_CLIENTS-1:0] grant_vec;
    logic                 last_slot;
    state_e               adv_state;
    logic [IW-1:0]        adv_idx;
    logic                 scoring;

    erase_sweep_counter #(
        .XW (XW),
        .YW (YW),
        .W  (SCREEN_W),
        .H  (SCREEN_H)
    ) u_erase (
        .clk    (clk),
        .resetn (resetn),
        .clr_i  (state_q == ST_IDLE),
        .en_i   (state_q == ST_ERASE),
        .x_o    (er_x),
        .y_o    (er_y),
        .last_o (er_last)
    );

    always_comb begin
        grant_vec        = '0;
        grant_vec[idx_q] = 1'b1;
    end

    // Slot advance target: last client hands over to the one-cycle score check.
    assign last_slot = (idx_q == IW'(N_CLIENTS - 1));
    assign adv_state = last_slot ? ST_CHECK : ST_DRAW;
    assign adv_idx   = last_slot ? '0 : idx_q + IW'(1);

    assign scoring = (state_q == ST_DRAW) || (state_q == ST_CHECK);

    always_comb begin
        score0_d = score0_q;
        score1_d = score1_q;
        if (state_q == ST_IDLE && go) begin
            score0_d = '0;
            score1_d = '0;
        end else if (scoring) begin
            if (score0_evt && score0_q < SCW'(WIN_SCORE)) score0_d = score0_q + SCW'(1);
            if (score1_evt && score1_q < SCW'(WIN_SCORE)) score1_d = score1_q + SCW'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= ST_IDLE;
            idx_q         <= '0;
            age_q         <= '0;
            cl_start_q    <= '0;
            x_q           <= '0;
            y_q           <= '0;
            colour_q      <= '0;
            plot_q        <= 1'b0;
            score0_q      <= '0;
            score1_q      <= '0;
            game_over_q   <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            score0_q <= score0_d;
            score1_q <= score1_d;
            plot_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (go) begin
                        state_q       <= ST_ERASE;
                        game_over_q   <= 1'b0;
                        timeout_err_q <= 1'b0;
                    end
                end
                ST_ERASE: begin
                    plot_q   <= 1'b1;
                    x_q      <= er_x;
                    y_q      <= er_y;
                    colour_q <= CW'(COLOUR_BLACK);
                    if (er_last) begin
                        state_q <= ST_DRAW;
                        idx_q   <= '0;
                    end
                end
                ST_DRAW: begin
                    // A slot with no grant yet is its entry cycle: enable is sampled here.
                    if (cl_start_q == '0) begin
                        if (client_en[idx_q]) begin
                            cl_start_q <= grant_vec;
                            age_q      <= '0;
                        end else begin
                            state_q <= adv_state;
                            idx_q   <= adv_idx;
                        end
                    end else begin
                        plot_q   <= cl_plot[idx_q] & cl_start_q[idx_q];
                        x_q      <= cl_x[idx_q*XW +: XW];
                        y_q      <= cl_y[idx_q*YW +: YW];
                        colour_q <= cl_colour[idx_q*CW +: CW];
                        if (cl_done[idx_q]) begin
                            cl_start_q <= '0;
                            state_q    <= adv_state;
                            idx_q      <= adv_idx;
                        end else if (age_q == TW'(TIMEOUT - 1)) begin
                            cl_start_q    <= '0;
                            timeout_err_q <= 1'b1;
                            state_q       <= adv_state;
                            idx_q         <= adv_idx;
                        end else begin
                            age_q <= age_q + TW'(1);
                        end
                    end
                end
                ST_CHECK: begin
                    if (score0_q >= SCW'(WIN_SCORE) || score1_q >= SCW'(WIN_SCORE)) begin
                        state_q     <= ST_IDLE;
                        game_over_q <= 1'b1;
                    end else begin
                        state_q <= ST_DRAW;
                        idx_q   <= '0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign cl_start    = cl_start_q;
    assign x_out       = x_q;
    assign y_out       = y_q;
    assign colour_out  = colour_q;
    assign plot_out    = plot_q;
    assign score0      = score0_q;
    assign score1      = score1_q;
    assign game_over   = game_over_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_frame_draw_sequencer.sv
// Scoreboard bench for frame_draw_sequencer: expected grants and plotted pixels are
// queued as stimulus is issued and consumed by an independent output monitor.
module tb_frame_draw_sequencer;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        go = 1'b0;
    logic [3:0]  client_en;
    logic [3:0]  cl_start;
    logic [3:0]  cl_done = '0;
    logic [3:0]  cl_plot;
    logic [31:0] cl_x;
    logic [27:0] cl_y;
    logic [11:0] cl_colour;
    logic        score0_evt = 1'b0;
    logic        score1_evt = 1'b0;
    logic [7:0]  x_out;
    logic [6:0]  y_out;
    logic [2:0]  colour_out;
    logic        plot_out;
    logic [3:0]  score0, score1;
    logic        game_over, timeout_err;

    always #5 clk = ~clk;

    frame_draw_sequencer #(
        .N_CLIENTS (4),
        .XW        (8),
        .YW        (7),
        .CW        (3),
        .SCREEN_W  (160),
        .SCREEN_H  (120),
        .SCW       (4),
        .WIN_SCORE (7),
        .TIMEOUT   (16)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .go          (go),
        .client_en   (client_en),
        .cl_start    (cl_start),
        .cl_done     (cl_done),
        .cl_plot     (cl_plot),
        .cl_x        (cl_x),
        .cl_y        (cl_y),
        .cl_colour   (cl_colour),
        .score0_evt  (score0_evt),
        .score1_evt  (score1_evt),
        .x_out       (x_out),
        .y_out       (y_out),
        .colour_out  (colour_out),
        .plot_out    (plot_out),
        .score0      (score0),
        .score1      (score1),
        .game_over   (game_over),
        .timeout_err (timeout_err)
    );

    typedef struct {
        logic [3:0] vec;
        int         gap;   // idle cycles since previous grant; -1 = don't care
    } grant_t;

    grant_t      gq[$];
    logic [17:0] pq[$];
    int          checks = 0;
    int          passes = 0;
    int          dly[4];
    int          cnt[4];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic logic [17:0] cpix(input int i);
        return {8'(20 + 10 * i), 7'(30 + 5 * i), 3'(i + 1)};
    endfunction

    task automatic push_erase(input int n);
        for (int k = 0; k < n; k++) pq.push_back({8'(k % 160), 7'(k / 160), 3'b000});
    endtask

    task automatic push_grant(input int i, input int gap, input int npix);
        grant_t g;
        g.vec = 4'(1 << i);
        g.gap = gap;
        gq.push_back(g);
        for (int k = 0; k < npix; k++) pq.push_back(cpix(i));
    endtask

    task automatic wait_grant(input logic [3:0] v, input int budget, input string name);
        int n = 0;
        while (cl_start !== v && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (cl_start !== v) check(name, int'(cl_start), int'(v));
    endtask

    task automatic wait_game_over(input string name);
        int n = 0;
        while (game_over !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(name, int'(game_over), 1);
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while ((pq.size() != 0 || gq.size() != 0) && n < budget) begin
            @(posedge clk);
            n++;
        end
        check("queues drained", pq.size() + gq.size(), 0);
    endtask

    task automatic pulse_go();
        @(negedge clk) go = 1'b1;
        @(negedge clk) go = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " cl_start"}, int'(cl_start), 0);
        check({tag, " plot_out"}, int'(plot_out), 0);
        check({tag, " x_out"}, int'(x_out), 0);
        check({tag, " y_out"}, int'(y_out), 0);
        check({tag, " colour_out"}, int'(colour_out), 0);
        check({tag, " score0"}, int'(score0), 0);
        check({tag, " score1"}, int'(score1), 0);
        check({tag, " game_over"}, int'(game_over), 0);
        check({tag, " timeout_err"}, int'(timeout_err), 0);
    endtask

    // Client models: plot continuously, raise done dly[i] cycles into the grant (0 = never).
    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                if (resetn && cl_start[i]) begin
                    cnt[i]++;
                    cl_done[i] = (dly[i] != 0) && (cnt[i] == dly[i]);
                end else begin
                    cnt[i] = 0;
                    cl_done[i] = 1'b0;
                end
            end
        end
    end

    // Output monitor.
    initial begin
        logic [3:0]  prev = '0;
        int          low = 0;
        grant_t      g;
        logic [17:0] p;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                prev = '0;
                low  = 0;
            end else begin
                if (cl_start != 4'b0000 && prev == 4'b0000) begin
                    if (gq.size() == 0) begin
                        check("unexpected grant", int'(cl_start), 0);
                    end else begin
                        g = gq.pop_front();
                        check("grant vector", int'(cl_start), int'(g.vec));
                        if (g.gap >= 0) check("grant idle gap", low, g.gap);
                    end
                    low = 0;
                end else if (cl_start == 4'b0000) begin
                    low++;
                end
                if (plot_out) begin
                    if (pq.size() == 0) begin
                        check("plot with empty queue", int'(plot_out), 0);
                    end else begin
                        p = pq.pop_front();
                        check("pixel {x,y,colour}", int'({x_out, y_out, colour_out}), int'(p));
                    end
                end
                prev = cl_start;
            end
        end
    end

    initial begin
        client_en = 4'b1111;
        cl_plot   = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            dly[i] = 5;
            cnt[i] = 0;
            cl_x[i*8 +: 8]      = 8'(20 + 10 * i);
            cl_y[i*7 +: 7]      = 7'(30 + 5 * i);
            cl_colour[i*3 +: 3] = 3'(i + 1);
        end

        // Reset values, then events in IDLE are dropped.
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        resetn = 1'b1;
        @(negedge clk) score0_evt = 1'b1;
        @(negedge clk) score0_evt = 1'b0;
        @(negedge clk);
        check("idle score0 dropped", int'(score0), 0);
        check("idle plot_out", int'(plot_out), 0);

        // Game A: full erase, two full frames, scoring ends the game.
        push_erase(19200);
        for (int f = 0; f < 2; f++)
            for (int i = 0; i < 4; i++)
                push_grant(i, (i != 0) ? 1 : ((f == 0) ? -1 : 2), 5);
        pulse_go();
        wait_grant(4'b1000, 20000, "game A frame1 client3 grant");
        wait_grant(4'b0001, 100, "game A frame2 client0 grant");
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            score0_evt = 1'b1;
            score1_evt = (k == 3);
        end
        @(negedge clk);
        score0_evt = 1'b0;
        score1_evt = 1'b0;
        wait_game_over("game A game_over");
        check("game A score0 saturated", int'(score0), 7);
        check("game A score1", int'(score1), 1);
        check("game A timeout_err", int'(timeout_err), 0);
        wait_drain(50);
        @(negedge clk) begin score0_evt = 1'b1; score1_evt = 1'b1; end
        @(negedge clk) begin score0_evt = 1'b0; score1_evt = 1'b0; end
        repeat (2) @(negedge clk);
        check("idle score0 held", int'(score0), 7);
        check("idle score1 held", int'(score1), 1);

        // Game B: client 2 disabled, client 1 never finishes.
        client_en = 4'b1011;
        dly[1] = 0;
        push_erase(19200);
        push_grant(0, -1, 5);
        push_grant(1, 1, 16);
        push_grant(3, 2, 5);
        pulse_go();
        repeat (2) @(negedge clk);
        check("go clears score0", int'(score0), 0);
        check("go clears score1", int'(score1), 0);
        check("go clears game_over", int'(game_over), 0);
        wait_grant(4'b0010, 20000, "game B client1 grant");
        check("timeout_err before timeout", int'(timeout_err), 0);
        for (int k = 0; k < 7; k++) @(negedge clk) score1_evt = 1'b1;
        @(negedge clk) score1_evt = 1'b0;
        wait_game_over("game B game_over");
        check("game B timeout_err", int'(timeout_err), 1);
        check("game B score1", int'(score1), 7);
        check("game B score0", int'(score0), 0);
        wait_drain(50);

        // Game C: reset asserted as client 2 is granted.
        client_en = 4'b1111;
        dly[1] = 5;
        push_erase(19200);
        push_grant(0, -1, 5);
        push_grant(1, 1, 5);
        push_grant(2, 1, 0);
        pulse_go();
        repeat (2) @(negedge clk);
        check("go clears timeout_err", int'(timeout_err), 0);
        wait_grant(4'b0100, 20000, "game C client2 grant");
        #1 resetn = 1'b0;
        #1 check_all_zero("mid-frame reset");
        wait_drain(5);

        // Restart after reset begins with an erase sweep from (0,0).
        @(negedge clk) resetn = 1'b1;
        push_erase(3);
        pulse_go();
        wait_drain(50);
        #1 resetn = 1'b0;
        #1 check("final reset plot_out", int'(plot_out), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
